// File: rtl/instr_sequencer.sv
// Multi-cycle control FSM for the miniRISC core: sequences fetch/decode/execute/memory/
// writeback over the shared memory, owns the {sign,carry,zero} flag register and resolves branches.
module instr_sequencer #(
  parameter int COUNT_W     = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         opcode,
  input  logic               alu_sign,
  input  logic               alu_carry,
  input  logic               alu_zero,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               mem_we,
  output logic               mem_addr_sel,
  output logic               ir_write,
  output logic               pc_write,
  output logic [1:0]         pc_src,
  output logic               reg_write,
  output logic [1:0]         wb_sel,
  output logic [2:0]         flags,
  output logic [COUNT_W-1:0] retired,
  output logic               halted,
  output logic               bus_error,
  output logic               illegal_op
);

  localparam logic [5:0] OP_ALU_R = 6'b000000;
  localparam logic [5:0] OP_ALU_I = 6'b000001;
  localparam logic [5:0] OP_LD    = 6'b000010;
  localparam logic [5:0] OP_ST    = 6'b000011;
  localparam logic [5:0] OP_BLTZ  = 6'b000111;
  localparam logic [5:0] OP_BZ    = 6'b001000;
  localparam logic [5:0] OP_BNZ   = 6'b001001;
  localparam logic [5:0] OP_BR    = 6'b001010;
  localparam logic [5:0] OP_B     = 6'b001011;
  localparam logic [5:0] OP_BL    = 6'b001100;
  localparam logic [5:0] OP_BCY   = 6'b001101;
  localparam logic [5:0] OP_BNCY  = 6'b001110;
  localparam logic [5:0] OP_NOP   = 6'b001111;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  localparam bit TIMEOUT_EN = (MEM_TIMEOUT > 0);
  localparam int WAIT_W     = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  // Last pending cycle allowed before the access is declared dead.
  localparam logic [WAIT_W-1:0] WAIT_LAST =
    WAIT_W'((MEM_TIMEOUT > 0) ? (MEM_TIMEOUT - 1) : 0);

  typedef enum logic [2:0] {
    S_INIT,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  state_t              state_q, state_d;
  logic [2:0]          flags_q, flags_d;
  logic [COUNT_W-1:0]  retired_q, retired_d;
  logic                bus_error_q, bus_error_d;
  logic                illegal_op_q, illegal_op_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;

  logic op_alu, op_ld, op_st, op_halt, op_br_reg, op_bl, op_illegal;
  logic br_taken;
  logic f_sign, f_carry, f_zero;
  logic wait_expired;

  // Opcode classification; branch conditions look only at the registered flags.
  always_comb begin
    op_alu     = 1'b0;
    op_ld      = 1'b0;
    op_st      = 1'b0;
    op_halt    = 1'b0;
    op_br_reg  = 1'b0;
    op_bl      = 1'b0;
    op_illegal = 1'b0;
    br_taken   = 1'b0;
    {f_sign, f_carry, f_zero} = flags_q;
    case (opcode)
      OP_ALU_R, OP_ALU_I: op_alu = 1'b1;
      OP_LD:   op_ld = 1'b1;
      OP_ST:   op_st = 1'b1;
      OP_BLTZ: br_taken = f_sign & ~f_zero;
      OP_BZ:   br_taken = ~f_sign & f_zero;
      OP_BNZ:  br_taken = ~f_zero;
      OP_BCY:  br_taken = f_carry;
      OP_BNCY: br_taken = ~f_carry;
      OP_B:    br_taken = 1'b1;
      OP_BR: begin
        br_taken  = 1'b1;
        op_br_reg = 1'b1;
      end
      OP_BL: begin
        br_taken = 1'b1;
        op_bl    = 1'b1;
      end
      OP_NOP:  ;
      OP_HALT: op_halt = 1'b1;
      default: op_illegal = 1'b1;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    flags_d      = flags_q;
    retired_d    = retired_q;
    bus_error_d  = bus_error_q;
    illegal_op_d = illegal_op_q;
    wait_cnt_d   = wait_cnt_q;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_src       = 2'd0;
    reg_write    = 1'b0;
    wb_sel       = 2'd0;
    halted       = 1'b0;
    wait_expired = TIMEOUT_EN && !mem_ready && (wait_cnt_q == WAIT_LAST);

    case (state_q)
      S_INIT: state_d = S_FETCH;

      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          state_d  = S_DECODE;
        end else if (wait_expired) begin
          bus_error_d = 1'b1;
          state_d     = S_HALT;
        end
      end

      S_DECODE: state_d = op_halt ? S_HALT : S_EXEC;

      S_EXEC: begin
        pc_write = 1'b1;
        if (br_taken) pc_src = op_br_reg ? 2'd2 : 2'd1;
        if (op_bl) begin
          reg_write = 1'b1;
          wb_sel    = 2'd2;
        end
        if (op_illegal) illegal_op_d = 1'b1;
        if (op_alu) begin
          flags_d = {alu_sign, alu_carry, alu_zero};
          state_d = S_WB;
        end else if (op_ld || op_st) begin
          state_d = S_MEM;
        end else begin
          state_d = S_FETCH;
        end
      end

      S_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = op_st;
        if (mem_ready) begin
          state_d = op_ld ? S_WB : S_FETCH;
        end else if (wait_expired) begin
          bus_error_d = 1'b1;
          state_d     = S_HALT;
        end
      end

      S_WB: begin
        reg_write = 1'b1;
        wb_sel    = op_ld ? 2'd1 : 2'd0;
        state_d   = S_FETCH;
      end

      S_HALT: halted = 1'b1;

      default: state_d = S_INIT;
    endcase

    // Any state change restarts the wait count, so every FETCH/MEM entry begins at zero.
    if (state_d != state_q) begin
      wait_cnt_d = '0;
    end else if (TIMEOUT_EN && mem_req && !mem_ready) begin
      wait_cnt_d = wait_cnt_q + WAIT_W'(1);
    end

    if ((state_d != state_q) &&
        ((state_d == S_HALT) ||
         ((state_d == S_FETCH) && (state_q inside {S_EXEC, S_MEM, S_WB})))) begin
      retired_d = retired_q + COUNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_INIT;
      flags_q      <= '0;
      retired_q    <= '0;
      bus_error_q  <= 1'b0;
      illegal_op_q <= 1'b0;
      wait_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      flags_q      <= flags_d;
      retired_q    <= retired_d;
      bus_error_q  <= bus_error_d;
      illegal_op_q <= illegal_op_d;
      wait_cnt_q   <= wait_cnt_d;
    end
  end

  assign flags      = flags_q;
  assign retired    = retired_q;
  assign bus_error  = bus_error_q;
  assign illegal_op = illegal_op_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: directed steps plus random instruction streams checked
// phase by phase against an instruction-level model of the sequencer.
module tb_instr_sequencer;

  localparam int CW  = 4;
  localparam int TMO = 4;

  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b000001;
  localparam logic [5:0] OP_LD   = 6'b000010;
  localparam logic [5:0] OP_ST   = 6'b000011;
  localparam logic [5:0] OP_BLTZ = 6'b000111;
  localparam logic [5:0] OP_BZ   = 6'b001000;
  localparam logic [5:0] OP_BNZ  = 6'b001001;
  localparam logic [5:0] OP_BR   = 6'b001010;
  localparam logic [5:0] OP_B    = 6'b001011;
  localparam logic [5:0] OP_BL   = 6'b001100;
  localparam logic [5:0] OP_BCY  = 6'b001101;
  localparam logic [5:0] OP_BNCY = 6'b001110;
  localparam logic [5:0] OP_NOP  = 6'b001111;
  localparam logic [5:0] OP_HALT = 6'b111111;

  logic          clk = 1'b0;
  logic          rst;
  logic [5:0]    opcode;
  logic          alu_sign, alu_carry, alu_zero, mem_ready;
  logic          mem_req, mem_we, mem_addr_sel, ir_write, pc_write, reg_write;
  logic [1:0]    pc_src, wb_sel;
  logic [2:0]    flags;
  logic [CW-1:0] retired;
  logic          halted, bus_error, illegal_op;

  instr_sequencer #(.COUNT_W(CW), .MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .opcode(opcode),
    .alu_sign(alu_sign), .alu_carry(alu_carry), .alu_zero(alu_zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr_sel(mem_addr_sel), .ir_write(ir_write), .pc_write(pc_write),
    .pc_src(pc_src), .reg_write(reg_write), .wb_sel(wb_sel), .flags(flags),
    .retired(retired), .halted(halted), .bus_error(bus_error), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Architectural model: what should be visible after each instruction.
  logic [2:0]    m_flags;
  logic [CW-1:0] m_retired;
  logic          m_bus, m_ill;

  logic [10:0] obs_str;
  assign obs_str = {mem_req, mem_we, mem_addr_sel, ir_write, pc_write, pc_src,
                    reg_write, wb_sel, halted};

  function automatic logic [10:0] str(input logic mreq, input logic we, input logic sel,
                                      input logic ir, input logic pcw, input logic [1:0] pcs,
                                      input logic rw, input logic [1:0] wbs, input logic h);
    return {mreq, we, sel, ir, pcw, pcs, rw, wbs, h};
  endfunction

  function automatic bit is_legal(input logic [5:0] op);
    return (op inside {OP_ADD, OP_ADDI, OP_LD, OP_ST, OP_BLTZ, OP_BZ, OP_BNZ, OP_BR,
                       OP_B, OP_BL, OP_BCY, OP_BNCY, OP_NOP, OP_HALT});
  endfunction

  function automatic bit taken(input logic [5:0] op, input logic [2:0] f);
    logic s, c, z;
    {s, c, z} = f;
    case (op)
      OP_BLTZ: return s & ~z;
      OP_BZ:   return ~s & z;
      OP_BNZ:  return ~z;
      OP_BCY:  return c;
      OP_BNCY: return ~c;
      OP_BR, OP_B, OP_BL: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_regs(input string tag);
    chk({tag, "_flags"}, 32'(flags), 32'(m_flags));
    chk({tag, "_retired"}, 32'(retired), 32'(m_retired));
    chk({tag, "_bus_error"}, 32'(bus_error), 32'(m_bus));
    chk({tag, "_illegal"}, 32'(illegal_op), 32'(m_ill));
  endtask

  task automatic scramble();
    mem_ready = 1'($urandom);
    {alu_sign, alu_carry, alu_zero} = 3'($urandom);
  endtask

  task automatic check_halt(input int n);
    for (int i = 0; i < n; i++) begin
      scramble();
      opcode = 6'($urandom);
      #1 chk("halt_str", 32'(obs_str), 32'(str(0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 1)));
      chk_regs("halt");
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    m_flags = '0; m_retired = '0; m_bus = 1'b0; m_ill = 1'b0;
    #1 chk("rst_str", 32'(obs_str), 32'd0);
    chk_regs("rst");
    @(negedge clk);
    rst = 1'b0;
    mem_ready = 1'b1;
    #1 chk("init_str", 32'(obs_str), 32'd0);
    @(negedge clk);
  endtask

  // Memory handshake (fetch or data access), bounded by the timeout window.
  task automatic mem_phase(input bit in_mem, input bit is_st, input int wait_n,
                           input logic [5:0] op, output bit tmo);
    bit rdy;
    tmo = 1'b0;
    for (int i = 0; i < TMO; i++) begin
      rdy = (i == wait_n);
      {alu_sign, alu_carry, alu_zero} = 3'($urandom);
      mem_ready = rdy;
      opcode = (in_mem || rdy) ? op : 6'($urandom);
      #1 chk(in_mem ? "mem_str" : "fetch_str", 32'(obs_str),
             32'(str(1, in_mem & is_st, in_mem, ~in_mem & rdy, 0, 2'd0, 0, 2'd0, 0)));
      @(negedge clk);
      if (rdy) return;
    end
    tmo = 1'b1;
    m_bus = 1'b1;
    m_retired = m_retired + 1'b1;
  endtask

  task automatic run_instr(input logic [5:0] op, input int fwait, input int mwait,
                           input logic [2:0] alu);
    bit tmo;
    bit ld, st, alu_op;
    logic [1:0] pcs;
    ld = (op == OP_LD);
    st = (op == OP_ST);
    alu_op = (op == OP_ADD) || (op == OP_ADDI);

    mem_phase(1'b0, 1'b0, fwait, op, tmo);
    if (tmo) begin
      check_halt(3);
      return;
    end

    scramble();
    #1 chk("decode_str", 32'(obs_str), 32'd0);
    @(negedge clk);
    if (op == OP_HALT) begin
      m_retired = m_retired + 1'b1;
      check_halt(3);
      return;
    end

    mem_ready = 1'($urandom);
    {alu_sign, alu_carry, alu_zero} = alu;
    pcs = taken(op, m_flags) ? ((op == OP_BR) ? 2'd2 : 2'd1) : 2'd0;
    #1 chk("exec_str", 32'(obs_str),
           32'(str(0, 0, 0, 0, 1, pcs, op == OP_BL, (op == OP_BL) ? 2'd2 : 2'd0, 0)));
    @(negedge clk);
    if (alu_op) m_flags = alu;
    if (!is_legal(op)) m_ill = 1'b1;

    if (ld || st) begin
      mem_phase(1'b1, st, mwait, op, tmo);
      if (tmo) begin
        check_halt(3);
        return;
      end
    end

    if (alu_op || ld) begin
      scramble();
      #1 chk("wb_str", 32'(obs_str), 32'(str(0, 0, 0, 0, 0, 2'd0, 1, ld ? 2'd1 : 2'd0, 0)));
      @(negedge clk);
    end

    m_retired = m_retired + 1'b1;
    chk_regs("retire");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bit tmo;
    logic [5:0] ops [14];
    logic [5:0] op;
    int idx, fw, mw;
    ops = '{OP_ADD, OP_ADDI, OP_LD, OP_ST, OP_BLTZ, OP_BZ, OP_BNZ, OP_BR,
            OP_B, OP_BL, OP_BCY, OP_BNCY, OP_NOP, OP_ADD};
    rst = 1'b0;
    opcode = '0;
    {alu_sign, alu_carry, alu_zero} = 3'b000;
    mem_ready = 1'b0;
    #1 rst = 1'b1;
    @(negedge clk);
    do_reset();

    // add with zero result, memory always ready
    run_instr(OP_ADD, 0, 0, 3'b001);
    chk("add_flags", 32'(flags), 32'b001);
    chk("add_retired", 32'(retired), 32'd1);
    // ld with two memory wait states
    run_instr(OP_LD, 0, 2, 3'b110);
    // branches against flags 001
    run_instr(OP_BZ, 0, 0, 3'b000);
    run_instr(OP_BCY, 0, 0, 3'b111);
    run_instr(OP_BL, 1, 0, 3'b000);
    run_instr(OP_BR, 0, 0, 3'b000);
    run_instr(OP_ADDI, 0, 0, 3'b110);
    run_instr(OP_BNCY, 0, 0, 3'b000);
    run_instr(OP_BLTZ, 0, 0, 3'b000);
    run_instr(OP_BNZ, 0, 0, 3'b000);
    // ready on the last allowed cycle must win over the timeout
    run_instr(OP_ADD, TMO - 1, 0, 3'b010);
    run_instr(OP_ST, TMO - 1, TMO - 1, 3'b000);
    chk("edge_bus_error", 32'(bus_error), 32'd0);

    for (int k = 0; k < 80; k++) begin
      idx = $urandom_range(0, 14);
      if (idx == 14) begin
        do op = 6'($urandom); while (is_legal(op));
      end else begin
        op = ops[idx];
      end
      fw = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, TMO - 1)) : 0;
      mw = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, TMO - 1)) : 0;
      run_instr(op, fw, mw, 3'($urandom));
    end

    // asynchronous reset in the middle of a ld memory access
    run_instr(OP_ADDI, 0, 0, 3'b111);
    mem_phase(1'b0, 1'b0, 0, OP_LD, tmo);
    mem_ready = 1'b0;
    #1 chk("rstmem_dec", 32'(obs_str), 32'd0);
    @(negedge clk);
    #1 chk("rstmem_exec", 32'(obs_str), 32'(str(0, 0, 0, 0, 1, 2'd0, 0, 2'd0, 0)));
    @(negedge clk);
    mem_ready = 1'b0;
    #1 chk("rstmem_mem", 32'(obs_str), 32'(str(1, 0, 1, 0, 0, 2'd0, 0, 2'd0, 0)));
    #1 rst = 1'b1;
    m_flags = '0; m_retired = '0; m_bus = 1'b0; m_ill = 1'b0;
    #1 chk("rstmem_str", 32'(obs_str), 32'd0);
    chk_regs("rstmem");
    @(negedge clk);
    rst = 1'b0;
    mem_ready = 1'b1;
    #1 chk("rstmem_init", 32'(obs_str), 32'd0);
    @(negedge clk);
    run_instr(OP_NOP, 0, 0, 3'b000);

    // fetch timeout
    do_reset();
    run_instr(OP_ADD, TMO + 2, 0, 3'b000);
    chk("tmo_fetch_bus", 32'(bus_error), 32'd1);
    chk("tmo_fetch_halt", 32'(halted), 32'd1);
    chk("tmo_fetch_req", 32'(mem_req), 32'd0);

    // data-access timeout after an ALU op set the flags
    do_reset();
    run_instr(OP_ADD, 0, 0, 3'b101);
    run_instr(OP_ST, 0, TMO + 1, 3'b000);
    chk("tmo_mem_bus", 32'(bus_error), 32'd1);

    // undefined opcode then halt
    do_reset();
    run_instr(6'b010101, 0, 0, 3'b111);
    chk("ill_sticky", 32'(illegal_op), 32'd1);
    run_instr(OP_HALT, 0, 0, 3'b000);
    chk("halt_retired", 32'(retired), 32'd2);
    chk("halt_illegal", 32'(illegal_op), 32'd1);

    // retired counter wraps at 2^CW
    do_reset();
    for (int k = 0; k < (1 << CW) - 1; k++) run_instr(OP_NOP, $urandom_range(0, 1), 0, 3'b000);
    chk("wrap_max", 32'(retired), 32'((1 << CW) - 1));
    run_instr(OP_B, 0, 0, 3'b000);
    chk("wrap_zero", 32'(retired), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
